// File: rtl/delayseq_pkg.sv
// Shared types and constants for the dead-time sequencer.
package delayseq_pkg;

   typedef enum logic [2:0] {
      st_off,
      st_dt_h,
      st_hs_on,
      st_dt_l,
      st_ls_on,
      st_fault
   } state_e;

   localparam int unsigned CNT_W_DEF = 6;
   // Floor applied to zero config values; also the "last cycle" count value.
   localparam int unsigned MIN_CNT   = 1;

endpackage

// File: rtl/delayseq_cnt.sv
// Loadable saturating down-counter; zero_nxt flags the cycle whose decrement ends the count.
module delayseq_cnt
   import delayseq_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic             dec,
   input  logic [CNT_W-1:0] ld_val,
   output logic             zero_nxt
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (ld) begin
         cnt_q <= ld_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // A count loaded with N expires after exactly N cycles in the owning state.
   assign zero_nxt = (cnt_q <= CNT_W'(MIN_CNT));

endmodule

// File: rtl/delayseq_deadtime_ctrl.sv
// Non-overlapping high/low-side gate enable sequencer with dead time, blanking and fault shutdown.
module delayseq_deadtime_ctrl
   import delayseq_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DT_RST    = 2,
   parameter int unsigned BLANK_RST = 4
) (
   input  logic             CELCLK,
   input  logic             CELRSTN,
   input  logic             pwm_i,
   input  logic [CNT_W-1:0] dt_cfg,
   input  logic [CNT_W-1:0] blank_cfg,
   input  logic             cfg_ld,
   input  logic             fault_i,
   input  logic             fault_clr,
   output logic             hs_en,
   output logic             ls_en,
   output logic             busy,
   output logic             fault_o
);

   function automatic logic [CNT_W-1:0] floor_cnt(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(MIN_CNT) : v;
   endfunction

   logic             pwm_m, pwm_s;
   logic [1:0]       sync_vld;
   logic [CNT_W-1:0] dt_r, blank_r, dt_nxt, blank_nxt;
   state_e           state_q, state_d;
   logic             dt_ld, dt_dec, dt_zero;
   logic             bl_ld, bl_dec, bl_zero;

   // sync_vld keeps OFF from deciding on pwm_s before the synchronizer has filled.
   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         pwm_m    <= 1'b0;
         pwm_s    <= 1'b0;
         sync_vld <= 2'b00;
      end else begin
         pwm_m    <= pwm_i;
         pwm_s    <= pwm_m;
         sync_vld <= {sync_vld[0], 1'b1};
      end
   end

   assign dt_nxt    = cfg_ld ? floor_cnt(dt_cfg) : dt_r;
   assign blank_nxt = cfg_ld ? floor_cnt(blank_cfg) : blank_r;

   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         dt_r    <= CNT_W'(DT_RST);
         blank_r <= CNT_W'(BLANK_RST);
      end else begin
         dt_r    <= dt_nxt;
         blank_r <= blank_nxt;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         st_off:   if (sync_vld[1]) state_d = pwm_s ? st_dt_h : st_ls_on;
         st_dt_h:  if (dt_zero) state_d = st_hs_on;
         st_hs_on: if (!pwm_s && bl_zero) state_d = st_dt_l;
         st_dt_l:  if (dt_zero) state_d = st_ls_on;
         st_ls_on: if (pwm_s) state_d = st_dt_h;
         st_fault: if (fault_clr) state_d = st_off;
         default:  state_d = st_off;
      endcase
      if (fault_i) begin
         state_d = st_fault;
      end
   end

   assign dt_ld  = (state_d != state_q) && ((state_d == st_dt_h) || (state_d == st_dt_l));
   assign bl_ld  = (state_d == st_hs_on) && (state_q != st_hs_on);
   assign dt_dec = (state_q == st_dt_h) || (state_q == st_dt_l);
   assign bl_dec = (state_q == st_hs_on);

   delayseq_cnt #(
      .CNT_W (CNT_W)
   ) u_dt_cnt (
      .clk      (CELCLK),
      .rst_n    (CELRSTN),
      .ld       (dt_ld),
      .dec      (dt_dec),
      .ld_val   (dt_nxt),
      .zero_nxt (dt_zero)
   );

   delayseq_cnt #(
      .CNT_W (CNT_W)
   ) u_blank_cnt (
      .clk      (CELCLK),
      .rst_n    (CELRSTN),
      .ld       (bl_ld),
      .dec      (bl_dec),
      .ld_val   (blank_nxt),
      .zero_nxt (bl_zero)
   );

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         state_q <= st_off;
         hs_en   <= 1'b0;
         ls_en   <= 1'b0;
         busy    <= 1'b0;
         fault_o <= 1'b0;
      end else begin
         state_q <= state_d;
         hs_en   <= (state_d == st_hs_on);
         ls_en   <= (state_d == st_ls_on);
         busy    <= (state_d == st_dt_h) || (state_d == st_dt_l);
         fault_o <= (state_d == st_fault);
      end
   end

endmodule

// File: tb/tb_delayseq_deadtime_ctrl.sv
// Scoreboard bench: stimulus pushes expected output changes, a monitor pops them on every change.
module tb_delayseq_deadtime_ctrl;

   logic       CELCLK  = 1'b0;
   logic       CELRSTN = 1'b1;
   logic       pwm_i, cfg_ld, fault_i, fault_clr;
   logic [5:0] dt_cfg, blank_cfg;
   logic       hs_en, ls_en, busy, fault_o;
   logic [3:0] out_vec;
   logic [3:0] prev_vec = 4'b0000;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_assert = 0;
   int   n_fail   = 0;

   delayseq_deadtime_ctrl #(
      .CNT_W     (6),
      .DT_RST    (2),
      .BLANK_RST (4)
   ) dut (
      .CELCLK    (CELCLK),
      .CELRSTN   (CELRSTN),
      .pwm_i     (pwm_i),
      .dt_cfg    (dt_cfg),
      .blank_cfg (blank_cfg),
      .cfg_ld    (cfg_ld),
      .fault_i   (fault_i),
      .fault_clr (fault_clr),
      .hs_en     (hs_en),
      .ls_en     (ls_en),
      .busy      (busy),
      .fault_o   (fault_o)
   );

   always #5 CELCLK = ~CELCLK;
   always @(posedge CELCLK) cyc <= cyc + 1;

   // {hs_en, ls_en, busy, fault_o}
   assign out_vec = {hs_en, ls_en, busy, fault_o};

   always @(negedge CELCLK) begin
      exp_t e;
      n_assert++;
      if (hs_en & ls_en) begin
         n_fail++;
         $display("FAIL overlap cyc=%0d hs_en=%b ls_en=%b required not both 1", cyc, hs_en, ls_en);
      end
      if (out_vec !== prev_vec) begin
         n_assert++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change cyc=%0d got=%b required=%b", cyc, out_vec, prev_vec);
         end else begin
            e = exp_q.pop_front();
            if ((e.vec !== out_vec) || (e.cyc != cyc)) begin
               n_fail++;
               $display("FAIL seq got=%b at cyc %0d required=%b at cyc %0d",
                        out_vec, cyc, e.vec, e.cyc);
            end
         end
         prev_vec = out_vec;
      end
   end

   task automatic goto(input int t);
      while (cyc < t) @(negedge CELCLK);
   endtask

   task automatic push(input int t, input logic [3:0] v);
      exp_q.push_back('{cyc: t, vec: v});
   endtask

   task automatic load_cfg(input logic [5:0] dt, input logic [5:0] bl);
      cfg_ld    = 1'b1;
      dt_cfg    = dt;
      blank_cfg = bl;
      @(negedge CELCLK);
      cfg_ld    = 1'b0;
   endtask

   task automatic check_now(input string name, input logic [3:0] want);
      n_assert++;
      if (out_vec !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, out_vec, want);
      end
   endtask

   initial begin
      int c;
      int r;
      pwm_i     = 1'b1;
      cfg_ld    = 1'b0;
      dt_cfg    = '0;
      blank_cfg = '0;
      fault_i   = 1'b0;
      fault_clr = 1'b0;
      #1 CELRSTN = 1'b0;
      repeat (3) @(negedge CELCLK);
      check_now("reset_outputs", 4'b0000);

      // Reset release with pwm held high: DT_H at edge 2, hs_en at edge 4 (edge 0 = first).
      c = cyc;
      CELRSTN = 1'b1;
      push(c + 3, 4'b0010);
      push(c + 5, 4'b1000);
      goto(c + 12);

      // Dead time 5 on the falling side.
      load_cfg(6'd5, 6'd4);
      c = cyc;
      pwm_i = 1'b0;
      push(c + 3, 4'b0010);
      push(c + 8, 4'b0100);
      goto(c + 12);

      // Blanking 8 holds hs_en although pwm drops early.
      load_cfg(6'd5, 6'd8);
      c = cyc;
      pwm_i = 1'b1;
      push(c + 3, 4'b0010);
      push(c + 8, 4'b1000);
      goto(c + 10);
      pwm_i = 1'b0;
      push(c + 16, 4'b0010);
      push(c + 21, 4'b0100);
      goto(c + 24);

      // Zero config floors to one cycle.
      load_cfg(6'd0, 6'd0);
      c = cyc;
      pwm_i = 1'b1;
      push(c + 3, 4'b0010);
      push(c + 4, 4'b1000);
      goto(c + 6);
      pwm_i = 1'b0;
      push(c + 9, 4'b0010);
      push(c + 10, 4'b0100);
      goto(c + 13);

      // cfg_ld on the DT_H entry edge: the new dead time of 3 applies.
      c = cyc;
      pwm_i = 1'b1;
      push(c + 3, 4'b0010);
      push(c + 6, 4'b1000);
      goto(c + 2);
      load_cfg(6'd3, 6'd1);
      goto(c + 9);

      // Fault in HS_ON; clear while fault_i is high is ignored.
      c = cyc;
      fault_i = 1'b1;
      push(c + 1, 4'b0001);
      goto(c + 1);
      fault_clr = 1'b1;
      goto(c + 2);
      fault_clr = 1'b0;
      goto(c + 3);
      fault_i = 1'b0;
      goto(c + 5);
      fault_clr = 1'b1;
      push(c + 6, 4'b0000);
      push(c + 7, 4'b0010);
      push(c + 10, 4'b1000);
      goto(c + 6);
      fault_clr = 1'b0;
      goto(c + 12);

      // Asynchronous reset in the middle of DT_H, then defaults 2/4 again.
      c = cyc;
      pwm_i = 1'b0;
      push(c + 3, 4'b0010);
      push(c + 6, 4'b0100);
      goto(c + 8);
      pwm_i = 1'b1;
      push(c + 11, 4'b0010);
      goto(c + 12);
      check_now("in_dt_h_before_reset", 4'b0010);
      #2 CELRSTN = 1'b0;
      push(c + 13, 4'b0000);
      #1 check_now("async_reset", 4'b0000);
      goto(c + 15);
      r = cyc;
      CELRSTN = 1'b1;
      push(r + 3, 4'b0010);
      push(r + 5, 4'b1000);
      goto(r + 5);
      pwm_i = 1'b0;
      push(r + 9, 4'b0010);
      push(r + 11, 4'b0100);
      goto(r + 16);

      n_assert++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0 next_cyc=%0d next_vec=%b",
                  exp_q.size(), exp_q[0].cyc, exp_q[0].vec);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/delayseq_deadtime_ctrl.md
# delayseq_deadtime_ctrl

Digital sequencer for the step-down loop's gate-drive path. It turns the loop's PWM request into non-overlapping high-side and low-side enables, with a programmable dead time and a minimum high-side on-time (blanking) counted in clock cycles. It feeds the fixed analog delay cells that follow in the XLOOP/XCONTROL path. It owns fault shutdown of both enables.

## Interface
Parameters:
- CNT_W, 6, width of dead-time and blanking counters and config ports.
- DT_RST, 2, dead-time cycles after reset, until first cfg_ld.
- BLANK_RST, 4, blanking cycles after reset, until first cfg_ld.

Ports:
- CELCLK  in  1  block clock; one clock only.
- CELRSTN  in  1  reset; asynchronous, active-low.
- pwm_i  in  1  PWM request, asynchronous to CELCLK; 1 = high side wanted.
- dt_cfg  in  CNT_W  dead-time length in cycles.
- blank_cfg  in  CNT_W  minimum HS_ON length in cycles.
- cfg_ld  in  1  one-cycle strobe; captures dt_cfg and blank_cfg into shadow registers.
- fault_i  in  1  synchronous fault request; level-sensitive.
- fault_clr  in  1  one-cycle strobe; releases the sticky fault.
- hs_en  out  1  high-side enable, registered.
- ls_en  out  1  low-side enable, registered.
- busy  out  1  high while in DT_H or DT_L.
- fault_o  out  1  sticky fault indicator, registered.

## Operation
- pwm_i passes through a 2-flop synchronizer to give pwm_s. Both flops reset to 0.
- Shadow registers:
  - dt_r and blank_r load on cfg_ld in any state.
  - A value of 0 is stored as 1, so the minimum dead time is 1 cycle.
  - A new value applies at the next entry to DT_H, DT_L or HS_ON. A count already running is not changed.
- FSM states: OFF, DT_H, HS_ON, DT_L, LS_ON, FAULT. Reset state is OFF.
- OFF: hs_en=0, ls_en=0.
  - pwm_s=1 → DT_H.
  - pwm_s=0 → LS_ON.
- DT_H: both enables 0.
  - Load the dead-time counter with dt_r on entry.
  - Go to HS_ON after exactly dt_r cycles in DT_H.
- HS_ON: hs_en=1.
  - Load the blanking counter with blank_r on entry.
  - Go to DT_L when pwm_s=0 and the blanking counter has expired.
  - pwm_s=0 during blanking is held off, not dropped: the transition happens on the first cycle after expiry if pwm_s is still 0.
- DT_L: both enables 0. Go to LS_ON after exactly dt_r cycles.
- LS_ON: ls_en=1. pwm_s=1 → DT_H.
- FAULT: both enables 0, fault_o=1.
  - From any state, fault_i=1 → FAULT on the next edge. Fault has priority over every other transition.
  - Leave FAULT only on fault_clr=1 with fault_i=0 in the same cycle; then go to OFF.
  - fault_clr while fault_i=1 is ignored.
- Invariant in every cycle, including reset and fault entry: hs_en & ls_en == 0.
- pwm_i toggling during DT_H or DT_L does not abort the dead time. The FSM finishes the dead time, then follows pwm_s on the next decision.

## Timing
- Reset values:
  - hs_en=0, ls_en=0, busy=0, fault_o=0.
  - State OFF, both counters 0.
  - dt_r=DT_RST, blank_r=BLANK_RST.
- CELRSTN going low mid-operation forces all outputs to 0 immediately and asynchronously.
- pwm_i rise to hs_en rise:
  - pwm_i is captured at edge 0 and pwm_s is high after edge 1.
  - DT_H is entered at edge 2; ls_en falls at edge 2.
  - hs_en rises at edge 2+dt_r.
  - The falling side has the same shape: hs_en falls at edge 2 (or at blanking expiry), ls_en rises dt_r edges later.
- fault_i sampled high at edge k: both enables are 0 and fault_o=1 after edge k.
- cfg_ld and a state entry on the same edge: the newly loaded value is used for that entry.
- Counters saturate at 0 and never wrap.

## Structure
- Package delayseq_pkg holds:
  - the state enum type,
  - CNT_W_DEF=6,
  - MIN_CNT=1 (the floor applied to zero config values).
- Sub-module delayseq_cnt: loadable CNT_W down-counter with a load input, a saturating decrement and a zero flag. Two instances: dead time and blanking.
- Top level holds the synchronizer, shadow registers, FSM and registered output decode.

## Test plan
- Reset with DT_RST=2 and pwm_i held 1 → OFF, then DT_H for 2 cycles, hs_en rises at edge 4 after reset release; ls_en never 1.
- cfg_ld with dt_cfg=5, then a pwm 1→0 edge → both enables 0 for exactly 5 cycles, then ls_en=1.
- blank_cfg=8, pwm high for only 2 cycles after hs_en rises → hs_en stays 1 for exactly 8 cycles, then DT_L.
- dt_cfg=0 loaded → every dead time measures 1 cycle; assertion that hs_en&ls_en is never 1 holds throughout.
- fault_i pulse during HS_ON → enables 0 next edge, fault_o=1:
  - fault_clr with fault_i=1 has no effect;
  - fault_clr with fault_i=0 → OFF, then normal sequencing resumes.
- CELRSTN asserted mid-DT_H → all outputs 0 without waiting for a clock edge; after release, state OFF and shadow registers back to DT_RST/BLANK_RST.
